bias_accum_ctrl: RTL and testbench

Sequencer for the per-layer bias stage of the adder-tree datapath. It takes N_adder_tree lanes of 18-bit partial sums from the adder tree over a programmable number of passes (kernel taps or input-channel tiles), accumulates them lane-wise, then adds the constant 18-bit bias vector from the layer's bias-constant block. It saturates each lane to 18 bits, optionally applies ReLU, and hands the result downstream on a valid/ready interface. One instance serves one output-channel group.

---
 rtl/bias_accum_if.sv | 34 +++
 rtl/bias_accum_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bias_accum_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_accum_if.sv
// Partial-sum / result handshake bundle for the bias stage.
// The master side is the upstream adder tree plus downstream consumer.
// The slave side is the bias_accum_ctrl sequencer.
interface bias_accum_if #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18
);

  logic                      in_valid;
  logic                      in_ready;
  logic [N_adder_tree*W-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_adder_tree*W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/bias_accum_ctrl.sv
// Per-layer bias stage sequencer.
// Accumulates n_pass beats of lane-wise partial sums, adds the bias vector,
// saturates each lane to W bits, optionally applies ReLU, then presents
// the result on a valid/ready output.
module bias_accum_ctrl #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18,
  parameter int ACC_W        = 26,
  parameter int PASS_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [PASS_W-1:0]         n_pass,
  input  logic                      relu_en,
  input  logic [N_adder_tree*W-1:0] bias_q,
  bias_accum_if.slave               bus,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_BIAS  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Saturation bounds expressed at the width of the biased sum.
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  state_t                    state_q,    state_d;
  logic [PASS_W-1:0]         cnt_q,      cnt_d;
  logic [PASS_W-1:0]         npass_q,    npass_d;
  logic                      relu_q,     relu_d;
  logic                      done_q,     done_d;
  logic [N_adder_tree*W-1:0] out_data_q, out_data_d;
  logic signed [ACC_W-1:0]   acc_q [N_adder_tree];
  logic signed [ACC_W-1:0]   acc_d [N_adder_tree];

  logic signed [W-1:0]       in_lane   [N_adder_tree];
  logic signed [W-1:0]       bias_lane [N_adder_tree];
  logic [PASS_W-1:0]         cnt_inc;
  logic                      in_fire;

  // Sign-extend a W-bit lane value to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [W-1:0] x);
    return {{(ACC_W-W){x[W-1]}}, x};
  endfunction

  // Accumulator plus bias, one guard bit wider so the add itself never wraps.
  function automatic logic signed [ACC_W:0] bias_add(input logic signed [ACC_W-1:0] acc,
                                                     input logic signed [W-1:0]     b);
    logic signed [ACC_W:0] a_ext;
    logic signed [ACC_W:0] b_ext;
    a_ext = {acc[ACC_W-1], acc};
    b_ext = {{(ACC_W+1-W){b[W-1]}}, b};
    return a_ext + b_ext;
  endfunction

  // Clamp a wide signed sum into the W-bit two's-complement range.
  function automatic logic [W-1:0] sat_w(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX) begin
      return {1'b0, {(W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      return {1'b1, {(W-1){1'b0}}};
    end else begin
      return v[W-1:0];
    end
  endfunction

  // Zero a negative lane when ReLU is enabled for this job.
  function automatic logic [W-1:0] relu_w(input logic [W-1:0] r, input logic en);
    return (en && r[W-1]) ? '0 : r;
  endfunction

  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    assign in_lane[g]   = bus.in_data[W*g +: W];
    assign bias_lane[g] = bias_q[W*g +: W];
  end

  assign cnt_inc = cnt_q + PASS_W'(1);
  assign in_fire = (state_q == S_ACCUM) && bus.in_valid;

  // Next-state, accumulation and result formation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    npass_d    = npass_q;
    relu_d     = relu_q;
    done_d     = 1'b0;
    out_data_d = out_data_q;
    for (int i = 0; i < N_adder_tree; i++) begin
      acc_d[i] = acc_q[i];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          npass_d = (n_pass == '0) ? PASS_W'(1) : n_pass;
          relu_d  = relu_en;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (in_fire) begin
          cnt_d = cnt_inc;
          // First beat loads directly so no separate clear cycle is needed.
          for (int i = 0; i < N_adder_tree; i++) begin
            if (cnt_q == '0) begin
              acc_d[i] = sext_acc(in_lane[i]);
            end else begin
              acc_d[i] = acc_q[i] + sext_acc(in_lane[i]);
            end
          end
          if (cnt_inc == npass_q) begin
            state_d = S_BIAS;
          end
        end
      end

      S_BIAS: begin
        for (int i = 0; i < N_adder_tree; i++) begin
          out_data_d[W*i +: W] = relu_w(sat_w(bias_add(acc_q[i], bias_lane[i])), relu_q);
        end
        state_d = S_OUT;
      end

      S_OUT: begin
        if (bus.out_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, configuration, accumulators and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      npass_q    <= '0;
      relu_q     <= 1'b0;
      done_q     <= 1'b0;
      out_data_q <= '0;
      for (int i = 0; i < N_adder_tree; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      npass_q    <= npass_d;
      relu_q     <= relu_d;
      done_q     <= done_d;
      out_data_q <= out_data_d;
      for (int i = 0; i < N_adder_tree; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_bias_accum_ctrl.sv
// Directed bench for bias_accum_ctrl: reset abort, accumulation latency,
// saturation, ReLU, backpressure with input bubbles, and edge configurations.
module tb_bias_accum_ctrl;

  localparam int N  = 16;
  localparam int W  = 18;
  localparam int PW = 8;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] n_pass;
  logic          relu_en;
  logic [VW-1:0] bias;
  logic          busy;
  logic          done;

  int n_assert = 0;
  int n_fail   = 0;

  bias_accum_if #(.N_adder_tree(N), .W(W)) bus ();

  bias_accum_ctrl #(
    .N_adder_tree(N),
    .W           (W),
    .ACC_W       (26),
    .PASS_W      (PW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n_pass (n_pass),
    .relu_en(relu_en),
    .bias_q (bias),
    .bus    (bus.slave),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int i);
    return v[W*i +: W];
  endfunction

  task automatic start_job(input logic [PW-1:0] np, input logic re);
    start   = 1'b1;
    n_pass  = np;
    relu_en = re;
    tick();
    start   = 1'b0;
    n_pass  = 8'hAA;
    relu_en = ~re;
  endtask

  task automatic beat();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_done"}, VW'(done), VW'(1'b1));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] exp5;
    int gap;

    rst           = 1'b1;
    start         = 1'b0;
    n_pass        = '0;
    relu_en       = 1'b0;
    bias          = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  VW'(bus.in_ready),  '0);
    check("rst_out_valid", VW'(bus.out_valid), '0);
    check("rst_busy",      VW'(busy),          '0);
    check("rst_done",      VW'(done),          '0);
    check("rst_out_data",  bus.out_data,       '0);
    rst = 1'b0;
    tick();

    // Reset mid-ACCUM after three beats aborts the job.
    for (int i = 0; i < N; i++) bus.in_data[W*i +: W] = 18'd77;
    start_job(8'd5, 1'b0);
    check("accum_in_ready", VW'(bus.in_ready), VW'(1'b1));
    repeat (3) beat();
    rst = 1'b1;
    tick();
    tick();
    check("abort_in_ready",  VW'(bus.in_ready),  '0);
    check("abort_out_valid", VW'(bus.out_valid), '0);
    check("abort_busy",      VW'(busy),          '0);
    check("abort_done",      VW'(done),          '0);
    rst = 1'b0;
    tick();

    // n_pass=1 job after reset: 100 + (-200) = -100.
    bus.in_data = '0;
    bus.in_data[17:0] = 18'd100;
    bias = '0;
    bias[17:0] = 18'h3FF38;
    start_job(8'd1, 1'b0);
    beat();
    tick();
    check("post_rst_valid", VW'(bus.out_valid), VW'(1'b1));
    check("post_rst_lane0", VW'(lane(bus.out_data, 0)), VW'(18'h3FF9C));
    check("post_rst_lane1", VW'(lane(bus.out_data, 1)), '0);
    finish_job("post_rst");
    tick();
    check("done_single", VW'(done), '0);

    // Nine beats of +1000 with lane5 bias -5408; latency of two cycles.
    bias = '0;
    bias[W*5 +: W] = 18'h3EAE0;
    for (int i = 0; i < N; i++) bus.in_data[W*i +: W] = 18'd1000;
    start_job(8'd9, 1'b0);
    repeat (9) beat();
    check("acc_t1_valid",    VW'(bus.out_valid), '0);
    check("acc_t1_in_ready", VW'(bus.in_ready),  '0);
    tick();
    check("acc_t2_valid", VW'(bus.out_valid), VW'(1'b1));
    check("acc_lane5",    VW'(lane(bus.out_data, 5)), VW'(18'd3592));
    check("acc_lane0",    VW'(lane(bus.out_data, 0)), VW'(18'd9000));
    finish_job("acc");

    // Positive and negative saturation.
    bias = '0;
    bias[W*0 +: W] = 18'd1;
    bias[W*1 +: W] = 18'h3FFFF;
    bus.in_data = '0;
    bus.in_data[W*0 +: W] = 18'h1FFFF;
    bus.in_data[W*1 +: W] = 18'h20000;
    bus.in_data[W*2 +: W] = 18'd5;
    start_job(8'd4, 1'b0);
    repeat (4) beat();
    tick();
    check("sat_valid", VW'(bus.out_valid), VW'(1'b1));
    check("sat_pos",   VW'(lane(bus.out_data, 0)), VW'(18'h1FFFF));
    check("sat_neg",   VW'(lane(bus.out_data, 1)), VW'(18'h20000));
    check("sat_none",  VW'(lane(bus.out_data, 2)), VW'(18'd20));
    finish_job("sat");

    // ReLU on, then the same vectors with ReLU off.
    bias = '0;
    bias[W*2 +: W] = 18'd20;
    bias[W*3 +: W] = 18'd20;
    bus.in_data = '0;
    bus.in_data[W*2 +: W] = 18'h3FFCE;
    bus.in_data[W*3 +: W] = 18'd50;
    start_job(8'd1, 1'b1);
    beat();
    tick();
    check("relu_neg", VW'(lane(bus.out_data, 2)), '0);
    check("relu_pos", VW'(lane(bus.out_data, 3)), VW'(18'd70));
    finish_job("relu");
    start_job(8'd1, 1'b0);
    beat();
    tick();
    check("norelu_neg", VW'(lane(bus.out_data, 2)), VW'(18'h3FFE2));
    check("norelu_pos", VW'(lane(bus.out_data, 3)), VW'(18'd70));
    finish_job("norelu");

    // Input bubbles, trailing in_valid outside ACCUM, and output backpressure.
    bias = '0;
    bus.in_data = '0;
    exp5 = '0;
    exp5[17:0] = 18'd210;
    start_job(8'd6, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        bus.in_valid = 1'b0;
        bus.in_data[17:0] = 18'd999;
        tick();
      end
      bus.in_data[17:0] = 18'(k * 10);
      beat();
    end
    bus.in_valid = 1'b1;
    bus.in_data[17:0] = 18'd5555;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", VW'(bus.out_valid), VW'(1'b1));
      check("bp_data",  bus.out_data,       exp5);
      check("bp_done",  VW'(done),          '0);
      tick();
    end
    finish_job("bp");
    tick();
    check("bp_done_once", VW'(done), '0);
    check("bp_idle",      VW'(busy), '0);

    // n_pass=0 acts as a single pass.
    bus.in_data = '0;
    bus.in_data[17:0] = 18'd7;
    start_job(8'd0, 1'b0);
    beat();
    check("np0_in_ready", VW'(bus.in_ready), '0);
    check("np0_busy",     VW'(busy),         VW'(1'b1));
    tick();
    check("np0_valid", VW'(bus.out_valid), VW'(1'b1));
    check("np0_lane0", VW'(lane(bus.out_data, 0)), VW'(18'd7));
    finish_job("np0");

    // Start during ACCUM must not change the latched n_pass or relu_en.
    start_job(8'd2, 1'b0);
    start   = 1'b1;
    n_pass  = 8'd5;
    relu_en = 1'b1;
    tick();
    start = 1'b0;
    bus.in_data[17:0] = 18'h3FFD8;
    beat();
    bus.in_data[17:0] = 18'h3FFC4;
    beat();
    tick();
    check("busy_start_valid", VW'(bus.out_valid), VW'(1'b1));
    check("busy_start_lane0", VW'(lane(bus.out_data, 0)), VW'(18'h3FF9C));

    // Back-to-back start in the done cycle.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("b2b_done", VW'(done), VW'(1'b1));
    start_job(8'd1, 1'b0);
    check("b2b_busy",     VW'(busy),         VW'(1'b1));
    check("b2b_in_ready", VW'(bus.in_ready), VW'(1'b1));
    check("b2b_done_low", VW'(done),         '0);
    bus.in_data[17:0] = 18'd123;
    beat();
    tick();
    check("b2b_lane0", VW'(lane(bus.out_data, 0)), VW'(18'd123));
    finish_job("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
